midi_to_ps2key: RTL and testbench

//  MIDI-in to ps2_key bridge. Receives serial MIDI on a user-port pin and parses Note On/Off.

---
 rtl/midi_ps2_pkg.sv | 39 +++
 rtl/midi_uart_rx.sv | 111 +++++++++++
 rtl/midi_to_ps2key.sv | 170 +++++++++++++++++
 tb/tb_midi_to_ps2key.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_ps2_pkg.sv
// Shared types and constants for the MIDI-in to ps2_key bridge:
// status nibbles, FSM state encodings, the piano-key scancode table and the event record.
package midi_ps2_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam int         NUM_KEYS = 24;

  typedef enum logic [1:0] {
    WAIT_STATUS,
    WAIT_NOTE,
    WAIT_VEL
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic       pressed;
    logic [7:0] scancode;
  } key_evt_t;

  // PS/2 set-2 codes for the two-row piano layout, lowest note first
  localparam logic [7:0] SCANCODE_TABLE [NUM_KEYS] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32,
    8'h33, 8'h31, 8'h3B, 8'h3A, 8'h15, 8'h1E, 8'h1D, 8'h26,
    8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C
  };

  function automatic logic [7:0] scancode_of(input logic [4:0] idx);
    scancode_of = 8'h00;
    if (idx < 5'(NUM_KEYS)) scancode_of = SCANCODE_TABLE[idx];
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver for MIDI: two-flop synchroniser, mid-bit sampling,
// one-cycle byte_valid on a good stop bit and one-cycle frame_err on a bad one.
module midi_uart_rx
  import midi_ps2_pkg::*;
#(
  parameter int CLK_DIV = 768
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);

  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[0], rx};
    prev_d  = rx_s;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_M1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          state_d = RX_IDLE;
          valid_d = rx_s;
          err_d   = !rx_s;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign rx_byte    = shift_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/midi_to_ps2key.sv
// MIDI Note On/Off to ps2_key bridge: UART receive, running-status parser,
// note-to-scancode mapping, event FIFO and a rate-limited toggle-strobe emitter.
module midi_to_ps2key
  import midi_ps2_pkg::*;
#(
  parameter int CLK_DIV    = 768,
  parameter int CHANNEL    = 0,
  parameter int BASE_NOTE  = 48,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP        = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        midi_rx,
  output logic [10:0] ps2_key,
  output logic        overflow,
  output logic        rx_error,
  input  logic        clr_flags
);

  localparam int            AW     = $clog2(FIFO_DEPTH);
  localparam int            GW     = $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_M1 = GW'(GAP - 1);
  localparam logic [7:0]    BASE8  = 8'(BASE_NOTE);
  localparam bit            OMNI   = (CHANNEL >= 16);
  localparam logic [3:0]    CHAN4  = 4'(CHANNEL);
  localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  midi_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (midi_rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  parse_state_e state_q, state_d;
  logic         rs_valid_q, rs_valid_d;
  logic         rs_on_q, rs_on_d;
  logic [6:0]   note_q, note_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [10:0]   ps2_key_q, ps2_key_d;
  logic          overflow_q, overflow_d;
  logic          rx_error_q, rx_error_d;
  key_evt_t      fifo_mem [FIFO_DEPTH];

  logic       is_realtime, chan_match, is_note_status;
  logic [7:0] note_ext, idx_full;
  logic       in_range, fifo_wr, pop, push, drop;
  key_evt_t   evt, head;

  assign is_realtime    = (rx_byte[7:3] == 5'b11111);
  assign chan_match     = OMNI || (rx_byte[3:0] == CHAN4);
  assign is_note_status = ((rx_byte[7:4] == NOTE_OFF) || (rx_byte[7:4] == NOTE_ON)) && chan_match;

  assign note_ext     = {1'b0, note_q};
  assign idx_full     = note_ext - BASE8;
  assign in_range     = (note_ext >= BASE8) && (idx_full < 8'(NUM_KEYS));
  assign evt.pressed  = rs_on_q && (rx_byte[6:0] != 7'd0);
  assign evt.scancode = scancode_of(idx_full[4:0]);

  // Velocity byte completes a message; out-of-table notes vanish silently
  assign fifo_wr = byte_valid && !rx_byte[7] && (state_q == WAIT_VEL) && in_range;

  always_comb begin
    state_d    = state_q;
    rs_valid_d = rs_valid_q;
    rs_on_d    = rs_on_q;
    note_d     = note_q;
    if (byte_valid && !is_realtime) begin
      if (rx_byte[7]) begin
        if (is_note_status) begin
          rs_valid_d = 1'b1;
          rs_on_d    = (rx_byte[7:4] == NOTE_ON);
          state_d    = WAIT_NOTE;
        end else begin
          rs_valid_d = 1'b0;
          state_d    = WAIT_STATUS;
        end
      end else begin
        case (state_q)
          WAIT_STATUS: begin
            if (rs_valid_q) begin
              note_d  = rx_byte[6:0];
              state_d = WAIT_VEL;
            end
          end
          WAIT_NOTE: begin
            note_d  = rx_byte[6:0];
            state_d = WAIT_VEL;
          end
          WAIT_VEL: state_d = WAIT_NOTE;
          default:  state_d = WAIT_STATUS;
        endcase
      end
    end
  end

  // A pop in the same cycle frees the slot that a write into a full queue needs
  assign head = fifo_mem[rd_ptr_q];
  assign pop  = (gap_cnt_q == '0) && (count_q != '0);
  assign push = fifo_wr && ((count_q != DEPTH) || pop);
  assign drop = fifo_wr && (count_q == DEPTH) && !pop;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    gap_cnt_d  = gap_cnt_q;
    ps2_key_d  = ps2_key_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      gap_cnt_d = GAP_M1;
      ps2_key_d = {~ps2_key_q[10], head.pressed, 1'b0, head.scancode};
    end else if (gap_cnt_q != '0) begin
      gap_cnt_d = gap_cnt_q - 1'b1;
    end
    overflow_d = drop ? 1'b1 : (clr_flags ? 1'b0 : overflow_q);
    rx_error_d = frame_err ? 1'b1 : (clr_flags ? 1'b0 : rx_error_q);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= evt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_STATUS;
      rs_valid_q <= 1'b0;
      rs_on_q    <= 1'b0;
      note_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gap_cnt_q  <= '0;
      ps2_key_q  <= '0;
      overflow_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_valid_q <= rs_valid_d;
      rs_on_q    <= rs_on_d;
      note_q     <= note_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gap_cnt_q  <= gap_cnt_d;
      ps2_key_q  <= ps2_key_d;
      overflow_q <= overflow_d;
      rx_error_q <= rx_error_d;
    end
  end

  assign ps2_key  = ps2_key_q;
  assign overflow = overflow_q;
  assign rx_error = rx_error_q;

endmodule

// File: tb/tb_midi_to_ps2key.sv
// Self-checking bench for midi_to_ps2key: vector table of MIDI messages, hand-written
// overflow / framing / reset sequences, and random traffic against a message-level model.
module tb_midi_to_ps2key;

  localparam int DIV   = 4;
  localparam int GAP   = 1200;
  localparam int CH    = 0;
  localparam int BASE  = 48;
  localparam int DEPTH = 8;
  localparam int NV    = 12;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        midi_rx = 1'b1;
  logic        clr_flags = 1'b0;
  logic [10:0] ps2_key;
  logic        overflow;
  logic        rx_error;

  midi_to_ps2key #(
    .CLK_DIV(DIV), .CHANNEL(CH), .BASE_NOTE(BASE), .FIFO_DEPTH(DEPTH), .GAP(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .midi_rx(midi_rx), .ps2_key(ps2_key),
    .overflow(overflow), .rx_error(rx_error), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Toggle monitor: every flip of ps2_key[10] is one emitted event
  int          cycle_no = 0;
  logic        last_tog = 1'b0;
  logic [9:0]  got_q[$];
  int          got_t[$];

  always @(negedge clk) begin
    cycle_no <= cycle_no + 1;
    if (!reset_n) last_tog <= 1'b0;
    else if (ps2_key[10] !== last_tog) begin
      last_tog <= ps2_key[10];
      got_q.push_back(ps2_key[9:0]);
      got_t.push_back(cycle_no);
    end
  end

  // Reference model: running status plus a list of pending data bytes
  logic [7:0] key_tbl [24] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32,
    8'h33, 8'h31, 8'h3B, 8'h3A, 8'h15, 8'h1E, 8'h1D, 8'h26,
    8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C
  };
  int         m_rs = -1;
  logic [7:0] m_data[$];
  logic [9:0] exp_q[$];

  task automatic model_byte(input logic [7:0] b);
    int idx;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      m_data.delete();
      if ((b[7:4] == 4'h8 || b[7:4] == 4'h9) && int'(b[3:0]) == CH) m_rs = int'(b);
      else m_rs = -1;
    end else if (m_rs >= 0) begin
      m_data.push_back(b);
      if (m_data.size() == 2) begin
        idx = int'(m_data[0]) - BASE;
        if (idx >= 0 && idx < 24)
          exp_q.push_back({(m_rs >= 8'h90) && (m_data[1] != 0), 1'b0, key_tbl[idx]});
        m_data.delete();
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    midi_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      tick(DIV);
    end
    midi_rx = stop_bit;
    tick(DIV);
    midi_rx = 1'b1;
    if (!stop_bit) tick(DIV);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1);
    model_byte(b);
  endtask

  task automatic wait_events(input int n, input int budget);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      tick(1);
      t++;
    end
  endtask

  task automatic clear_seen();
    got_q.delete();
    got_t.delete();
  endtask

  typedef struct packed {
    logic [39:0] bytes;
    logic [2:0]  n;
    logic [1:0]  n_evt;
    logic [9:0]  e0;
    logic [9:0]  e1;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    vec_t       v;
    int         min_gap;
    int         r;
    logic [7:0] st, note, vel;

    vecs[0]  = '{40'h903C64_0000, 3'd3, 2'd1, 10'h215, 10'h000};
    vecs[1]  = '{40'h903040_3000, 3'd5, 2'd2, 10'h21A, 10'h01A};
    vecs[2]  = '{40'h90F83C_FE40, 3'd5, 2'd1, 10'h215, 10'h000};
    vecs[3]  = '{40'h913C40_0000, 3'd3, 2'd0, 10'h000, 10'h000};
    vecs[4]  = '{40'h902040_0000, 3'd3, 2'd0, 10'h000, 10'h000};
    vecs[5]  = '{40'h804740_0000, 3'd3, 2'd1, 10'h03C, 10'h000};
    vecs[6]  = '{40'h904810_0000, 3'd3, 2'd0, 10'h000, 10'h000};
    vecs[7]  = '{40'h902F10_0000, 3'd3, 2'd0, 10'h000, 10'h000};
    vecs[8]  = '{40'h90477F_0000, 3'd3, 2'd1, 10'h23C, 10'h000};
    vecs[9]  = '{40'hF03C40_0000, 3'd3, 2'd0, 10'h000, 10'h000};
    vecs[10] = '{40'h903C00_0000, 3'd3, 2'd1, 10'h015, 10'h000};
    vecs[11] = '{40'h903B01_0000, 3'd3, 2'd1, 10'h23A, 10'h000};

    tick(5);
    check("reset_ps2_key", 32'(ps2_key), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    check("reset_rx_error", 32'(rx_error), 32'h0);
    reset_n = 1'b1;
    tick(DIV * 4);

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      tick(GAP + 20);
      clear_seen();
      for (int i = 0; i < int'(v.n); i++) send(v.bytes[39 - 8 * i -: 8]);
      if (v.n_evt == 2'd1) begin
        tick(4);
        check($sformatf("vec%0d_latency", k), 32'(got_q.size() >= 1), 32'h1);
      end
      wait_events(int'(v.n_evt), 3 * GAP);
      tick(20);
      check($sformatf("vec%0d_count", k), 32'(got_q.size()), 32'(v.n_evt));
      if (v.n_evt >= 2'd1 && got_q.size() >= 1) check($sformatf("vec%0d_evt0", k), 32'(got_q[0]), 32'(v.e0));
      if (v.n_evt >= 2'd2 && got_q.size() >= 2) begin
        check($sformatf("vec%0d_evt1", k), 32'(got_q[1]), 32'(v.e1));
        check($sformatf("vec%0d_gap", k), 32'(got_t[1] - got_t[0] >= GAP), 32'h1);
      end
      $display("vec %0d: %0d bytes sent, %0d events seen", k, v.n, got_q.size());
    end

    // Burst of 12 Note Ons right behind an emitted event: 8 queue, 4 drop
    tick(GAP + 20);
    clear_seen();
    check("ovf_pre", 32'(overflow), 32'h0);
    send(8'h90); send(8'h40); send(8'h40);
    for (int i = 0; i < 12; i++) begin
      send(8'(BASE + i));
      send(8'h40);
    end
    check("ovf_set", 32'(overflow), 32'h1);
    wait_events(9, 11 * GAP);
    tick(GAP + 20);
    check("ovf_burst_emitted", 32'(got_q.size() - 1), 32'd8);
    if (got_q.size() >= 1) check("ovf_lead_evt", 32'(got_q[0]), 32'h224);
    for (int i = 1; i < 9 && i < got_q.size(); i++)
      check($sformatf("ovf_evt%0d", i), 32'(got_q[i]), 32'({1'b1, 1'b0, key_tbl[i-1]}));
    min_gap = 1 << 30;
    for (int i = 1; i < got_t.size(); i++)
      if (got_t[i] - got_t[i-1] < min_gap) min_gap = got_t[i] - got_t[i-1];
    check("ovf_min_gap", 32'(min_gap >= GAP), 32'h1);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    tick(1);
    check("ovf_cleared", 32'(overflow), 32'h0);
    $display("overflow burst: %0d events seen", got_q.size());

    // Bad stop bit on the status byte: error flagged, message lost
    clear_seen();
    send(8'hF0);
    send_byte(8'h90, 1'b0);
    send(8'h3C);
    send(8'h40);
    tick(20);
    check("framing_rx_error", 32'(rx_error), 32'h1);
    check("framing_no_event", 32'(got_q.size()), 32'h0);
    $display("framing error: rx_error=%0b, %0d events seen", rx_error, got_q.size());

    // Reset in the middle of a message's final byte
    send(8'h90);
    send(8'h3C);
    midi_rx = 1'b0;
    tick(DIV * 3 + 1);
    reset_n = 1'b0;
    m_rs = -1;
    m_data.delete();
    tick(3);
    check("midreset_ps2_key", 32'(ps2_key), 32'h0);
    check("midreset_overflow", 32'(overflow), 32'h0);
    check("midreset_rx_error", 32'(rx_error), 32'h0);
    midi_rx = 1'b1;
    reset_n = 1'b1;
    tick(DIV * 12);
    clear_seen();
    send(8'h40);
    tick(20);
    check("midreset_orphan_data", 32'(got_q.size()), 32'h0);
    send(8'h90); send(8'h3C); send(8'h40);
    wait_events(1, 100);
    tick(5);
    check("midreset_next_count", 32'(got_q.size()), 32'h1);
    if (got_q.size() >= 1) check("midreset_next_evt", 32'(got_q[0]), 32'h215);
    $display("reset mid-byte: %0d events after recovery", got_q.size());

    // Random traffic against the model
    for (int b = 0; b < 2; b++) begin
      tick(GAP + 20);
      clear_seen();
      exp_q.delete();
      for (int m = 0; m < 8; m++) begin
        r = $urandom_range(0, 4);
        case (r)
          0: st = 8'h90;
          1: st = 8'h80;
          2: st = 8'h91;
          3: st = 8'hB0;
          default: st = 8'h00;
        endcase
        if (st != 8'h00) send(st);
        if ($urandom_range(0, 3) == 0) send(8'hF8);
        note = 8'($urandom_range(BASE - 4, BASE + 27));
        vel  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
        send(note);
        send(vel);
      end
      wait_events(exp_q.size(), (exp_q.size() + 1) * GAP + 100);
      tick(50);
      check($sformatf("rand%0d_count", b), 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check($sformatf("rand%0d_evt%0d", b, i), 32'(got_q[i]), 32'(exp_q[i]));
      check($sformatf("rand%0d_no_overflow", b), 32'(overflow), 32'h0);
      $display("random batch %0d: %0d events expected, %0d seen", b, exp_q.size(), got_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
